// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, valid/ready on both sides.
// Define BOOTH_SIGNED_MODE_EN to add the signed_mode port; otherwise operands are always signed.
module booth_radix4_seq #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
`ifdef BOOTH_SIGNED_MODE_EN
  input  logic           signed_mode,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] y,
  output logic           busy
);

  localparam int W    = 2 * N;
  localparam int NB   = N + 3;
  localparam int NDIG = N / 2 + 1;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(N / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_mcand;
  logic [NB-1:0] r_b;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_y;

  logic          w_signed;
  logic [W-1:0]  w_a_ext;
  logic [NB-1:0] w_b_ext;
  logic [W-1:0]  w_pp;
  logic [W-1:0]  w_acc_next;
  logic          w_last;
  logic          w_accept;

`ifdef BOOTH_SIGNED_MODE_EN
  assign w_signed = signed_mode;
`else
  assign w_signed = 1'b1;
`endif

  // Multiplier keeps a zero below bit 0 so the lowest triplet sees B[-1]=0.
  assign w_a_ext = {{(W - N){w_signed & A[N-1]}}, A};
  assign w_b_ext = {{2{w_signed & B[N-1]}}, B, 1'b0};

  assign w_last   = (r_cnt == LAST);
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // r_mcand is already aligned at bit 2i, so only the Booth multiple is chosen here.
  always_comb begin
    w_pp = '0;
    case (r_b[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = {r_mcand[W-2:0], 1'b0};
      3'b100:         w_pp = -{r_mcand[W-2:0], 1'b0};
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_mcand <= w_a_ext;
      r_b     <= w_b_ext;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_acc   <= w_acc_next;
      r_mcand <= {r_mcand[W-3:0], 2'b00};
      r_b     <= {{2{r_b[NB-1]}}, r_b[NB-1:2]};
      r_cnt   <= r_cnt + CW'(1);
      // Result register only changes on DONE entry; it holds through IDLE.
      if (w_last) begin
        r_y <= w_acc_next;
      end
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Bench for booth_radix4_seq: directed N=32 cases plus random N=8 traffic against an arithmetic model.
module tb_booth_radix4_seq;

`ifdef BOOTH_SIGNED_MODE_EN
  localparam bit HAS_SM = 1'b1;
`else
  localparam bit HAS_SM = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, busy32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] y32;
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] y8;
`ifdef BOOTH_SIGNED_MODE_EN
  logic        sm32 = 1'b1, sm8 = 1'b1;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  booth_radix4_seq #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
`ifdef BOOTH_SIGNED_MODE_EN
    .signed_mode(sm32),
`endif
    .out_valid(ov32), .out_ready(or32), .y(y32), .busy(busy32)
  );

  booth_radix4_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
`ifdef BOOTH_SIGNED_MODE_EN
    .signed_mode(sm8),
`endif
    .out_valid(ov8), .out_ready(or8), .y(y8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic eff_sm(input logic sm);
    return HAS_SM ? sm : 1'b1;
  endfunction

  // Reference: plain integer product of the operands interpreted per mode.
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int pa, pb;
    pa = sm ? int'($signed(a)) : int'(a);
    pb = sm ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    iv32 = 1'b1;
    a32  = a;
    b32  = b;
`ifdef BOOTH_SIGNED_MODE_EN
    sm32 = sm;
`endif
    @(posedge clk); #1;
    iv32 = 1'b0;
    a32  = $urandom;
    b32  = $urandom;
`ifdef BOOTH_SIGNED_MODE_EN
    sm32 = ~sm;
`endif
  endtask

  task automatic finish32(input logic [63:0] exp, input string tag);
    repeat (16) @(posedge clk);
    #1;
    check({tag, "_early"}, {63'b0, ov32}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {63'b0, ov32}, 64'd1);
    check({tag, "_y"}, y32, exp);
    check({tag, "_ready"}, {63'b0, ir32}, 64'd0);
    $display("op %s: y=%h expected=%h", tag, y32, exp);
  endtask

  task automatic release32(input logic [63:0] exp, input string tag);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check({tag, "_drop"}, {63'b0, ov32}, 64'd0);
    check({tag, "_hold"}, y32, exp);
    check({tag, "_idle"}, {62'b0, busy32, ir32}, 64'd1);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rsm;
    logic        seen;
    int          cyc;

    #2 rst_n = 1'b0;
    #1;
    check("rst_y", y32, 64'd0);
    check("rst_flags", {60'b0, ir32, ov32, busy32, 1'b0}, 64'd8);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Operand accepted on the very first edge after reset release.
    start32(32'hFFFF_FFF9, 32'd3, 1'b1);
    finish32(64'hFFFF_FFFF_FFFF_FFEB, "m7x3");
    release32(64'hFFFF_FFFF_FFFF_FFEB, "m7x3");

    start32(32'h8000_0000, 32'h8000_0000, 1'b1);
    finish32(64'h4000_0000_0000_0000, "minxmin");
    release32(64'h4000_0000_0000_0000, "minxmin");

    start32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    finish32(64'hC000_0000_8000_0000, "minxmax");
    release32(64'hC000_0000_8000_0000, "minxmax");

    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    finish32(64'h1, "m1xm1");
    release32(64'h1, "m1xm1");

`ifdef BOOTH_SIGNED_MODE_EN
    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    finish32(64'hFFFF_FFFE_0000_0001, "uffxff");
    release32(64'hFFFF_FFFE_0000_0001, "uffxff");
`endif

    // Backpressure with a competing operand offered during DONE.
    start32(32'd1234, 32'd5678, 1'b1);
    finish32(64'd7006652, "bp");
    iv32 = 1'b1;
    a32  = 32'd99;
    b32  = 32'd77;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'b0, ov32}, 64'd1);
      check("bp_y", y32, 64'd7006652);
      check("bp_ready", {63'b0, ir32}, 64'd0);
    end
    iv32 = 1'b0;
    release32(64'd7006652, "bp");
    @(posedge clk); #1;
    check("bp_noaccept", {63'b0, busy32}, 64'd0);

    // Abort in CALC cycle 5.
    start32(32'd1000, 32'd1000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_y", y32, 64'd0);
    check("abort_flags", {61'b0, ir32, ov32, busy32}, 64'd4);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      seen = seen | ov32;
    end
    check("abort_noval", {63'b0, seen}, 64'd0);
    start32(32'd12, 32'hFFFF_FFFB, 1'b1);
    finish32(64'hFFFF_FFFF_FFFF_FFC4, "12xm5");
    release32(64'hFFFF_FFFF_FFFF_FFC4, "12xm5");

    // Random N=8 traffic with random out_ready throughout.
    for (int k = 0; k < 1000; k++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsm = 1'($urandom);
      iv8 = 1'b1;
      a8  = ra;
      b8  = rb;
`ifdef BOOTH_SIGNED_MODE_EN
      sm8 = rsm;
`endif
      @(posedge clk); #1;
      iv8 = 1'b0;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
`ifdef BOOTH_SIGNED_MODE_EN
      sm8 = 1'($urandom);
`endif
      cyc = 0;
      while (!ov8 && cyc < 40) begin
        or8 = 1'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
      check("r8_lat", 64'(cyc), 64'd5);
      check("r8_y", {48'b0, y8}, {48'b0, model8(ra, rb, eff_sm(rsm))});
      $display("r8 %0d: A=%h B=%h sm=%0d y=%h", k, ra, rb, eff_sm(rsm), y8);
      or8 = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
